// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the MEM-stage data-memory responder.
//   state_t      - responder FSM states (IDLE, BUSY, DONE)
//   DMEM_WORD_W  - data word width
//   idx_w()      - word-index width for a given array depth
package dmem_pkg;

    localparam int unsigned DMEM_WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned idx_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: EX/MEM memory-control bundle between the pipeline and the responder.
//   MemRead  - load request          MemWrite - store request (wins if both set)
//   addr     - byte address          wdata    - store data
//   rdata    - registered load data  stall    - pipeline freeze
//   err      - sticky address error (present only when DMEM_ERR_EN is defined)
// Modports: master = pipeline side, slave = responder side.
interface dmem_responder_if;
    import dmem_pkg::*;

    logic                   MemRead;
    logic                   MemWrite;
    logic [DMEM_WORD_W-1:0] addr;
    logic [DMEM_WORD_W-1:0] wdata;
    logic [DMEM_WORD_W-1:0] rdata;
    logic                   stall;
`ifdef DMEM_ERR_EN
    logic                   err;

    modport master (
        output MemRead, MemWrite, addr, wdata,
        input  rdata, stall, err
    );

    modport slave (
        input  MemRead, MemWrite, addr, wdata,
        output rdata, stall, err
    );
`else
    modport master (
        output MemRead, MemWrite, addr, wdata,
        input  rdata, stall
    );

    modport slave (
        input  MemRead, MemWrite, addr, wdata,
        output rdata, stall
    );
`endif

endinterface

// File: rtl/dmem_array.sv
// dmem_array: single-port DEPTH x 32 storage, synchronous write and synchronous read.
//   clk_i      - clock, rising edge
//   rst_i      - asynchronous active-low reset (clears the read register only)
//   readEn_i   - capture mem[idx_i] into rdata_o on this edge
//   writeEn_i  - write wdata_i to mem[idx_i] on this edge
//   idx_i      - word index
//   wdata_i    - write data
//   rdata_o    - registered read data, holds between reads
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      readEn_i,
    input  logic                      writeEn_i,
    input  logic [idx_w(DEPTH)-1:0]   idx_i,
    input  logic [DMEM_WORD_W-1:0]    wdata_i,
    output logic [DMEM_WORD_W-1:0]    rdata_o
);

    logic [DMEM_WORD_W-1:0] mem [DEPTH];
    logic [DMEM_WORD_W-1:0] rdataQ;

    // Contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (writeEn_i) begin
            mem[idx_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdataQ <= '0;
        end else if (readEn_i) begin
            rdataQ <= mem[idx_i];
        end
    end

    assign rdata_o = rdataQ;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data-memory responder with fixed multi-cycle latency.
// Each access stalls the pipeline for LATENCY cycles, then spends one DONE cycle with
// stall low; the array is accessed on the edge entering DONE.
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-low reset
//   bus    - dmem_responder_if.slave (MemRead, MemWrite, addr, wdata -> rdata, stall[, err])
// Optional feature macro: DMEM_ERR_EN adds the sticky misaligned/out-of-range error flag.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dmem_responder_if.slave  bus
);

    localparam int unsigned IdxW = idx_w(DEPTH);
    localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t                 stateQ, stateD;
    logic [CntW-1:0]        cntQ, cntD;
    logic                   req;
    logic                   stallRaw;
    logic                   enterDone;
    logic                   accessEn;
    logic [IdxW-1:0]        idx;
    logic [DMEM_WORD_W-1:0] rdata;

    assign req = bus.MemRead | bus.MemWrite;
    assign idx = bus.addr[IdxW+1:2];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stateQ <= IDLE;
            cntQ   <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
        end
    end

    always_comb begin
        stateD    = stateQ;
        cntD      = cntQ;
        stallRaw  = 1'b0;
        enterDone = 1'b0;
        unique case (stateQ)
            IDLE: begin
                stallRaw = req;
                if (req) begin
                    cntD = CntW'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        stateD    = DONE;
                        enterDone = 1'b1;
                    end else begin
                        stateD = BUSY;
                    end
                end
            end
            BUSY: begin
                // Completes even if req drops; the access is already committed.
                stallRaw = 1'b1;
                cntD     = cntQ - 1'b1;
                if (cntQ == CntW'(1)) begin
                    stateD    = DONE;
                    enterDone = 1'b1;
                end
            end
            DONE: begin
                // Never starts an access: a request seen here is the one just served.
                stateD = IDLE;
            end
            default: begin
                stateD = IDLE;
            end
        endcase
    end

    // Gate with reset so a held reset neither stalls nor writes (matters for LATENCY==1).
    assign bus.stall = stallRaw & rst_i;
    assign accessEn  = enterDone & rst_i;

    dmem_array #(
        .DEPTH (DEPTH)
    ) uArray (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .readEn_i  (accessEn & ~bus.MemWrite),
        .writeEn_i (accessEn & bus.MemWrite),
        .idx_i     (idx),
        .wdata_i   (bus.wdata),
        .rdata_o   (rdata)
    );

    assign bus.rdata = rdata;

`ifdef DMEM_ERR_EN
    logic errQ;
    logic addrBad;

    assign addrBad = (bus.addr[1:0] != 2'b00) || ((bus.addr >> (IdxW + 2)) != '0);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            errQ <= 1'b0;
        end else if (accessEn && addrBad) begin
            errQ <= 1'b1;
        end
    end

    assign bus.err = errQ;
`else
    // Byte offset and upper address bits are ignored: the index wraps silently.
    logic unusedAddrBits;
    assign unusedAddrBits = ^{bus.addr[1:0], bus.addr >> (IdxW + 2)};
`endif

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    import dmem_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();

    dmem_responder #(
        .DEPTH   (256),
        .LATENCY (3)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus0.slave)
    );

    dmem_responder #(
        .DEPTH   (256),
        .LATENCY (1)
    ) dut1 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus1.slave)
    );

    // Behavioural model: word memory per DUT and the expected outputs of the current cycle.
    logic [31:0] mdl       [2][256];
    logic        expStall  [2];
    logic [31:0] expRdata  [2];
    logic        expErr    [2];
    bit          chkEn = 1'b0;

    // Hand-computed literal expectations, one per cycle, handed to the compare process.
    int          pinSeq  = 0;
    int          pinWhich;
    int          pinKind;   // 0: rdata, 1: err
    string       pinName = "";
    logic [31:0] pinVal;

    int nCmp    = 0;
    int nBad    = 0;
    int pinDone = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (chkEn) begin
            cmp("stall0", {31'b0, bus0.stall}, {31'b0, expStall[0]});
            cmp("rdata0", bus0.rdata, expRdata[0]);
            cmp("stall1", {31'b0, bus1.stall}, {31'b0, expStall[1]});
            cmp("rdata1", bus1.rdata, expRdata[1]);
`ifdef DMEM_ERR_EN
            cmp("err0", {31'b0, bus0.err}, {31'b0, expErr[0]});
            cmp("err1", {31'b0, bus1.err}, {31'b0, expErr[1]});
`endif
        end
        if (pinSeq != pinDone) begin
            pinDone = pinSeq;
            if (pinKind == 0) begin
                cmp(pinName, (pinWhich == 0) ? bus0.rdata : bus1.rdata, pinVal);
`ifdef DMEM_ERR_EN
            end else begin
                cmp(pinName, {31'b0, (pinWhich == 0) ? bus0.err : bus1.err}, pinVal);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic setIn(input int w, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (w == 0) begin
            bus0.MemRead = rd; bus0.MemWrite = wr; bus0.addr = a; bus0.wdata = d;
        end else begin
            bus1.MemRead = rd; bus1.MemWrite = wr; bus1.addr = a; bus1.wdata = d;
        end
    endtask

    task automatic pin(input int w, input int kind, input string name, input logic [31:0] v);
        pinWhich = w;
        pinKind  = kind;
        pinName  = name;
        pinVal   = v;
        pinSeq++;
    endtask

    // One access: LATENCY stall cycles, then a DONE cycle with the result; returns in the
    // cycle after DONE with inputs idle, so a following call is back-to-back.
    task automatic access(input int w, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input bit doPin, input logic [31:0] pv, input string pn);
        int lat = (w == 0) ? 3 : 1;
        int idx = int'((a >> 2) & 32'hFF);
        setIn(w, rd, wr, a, d);
        for (int k = 0; k < lat; k++) begin
            expStall[w] = 1'b1;
            tick();
        end
        expStall[w] = 1'b0;
        if (wr) mdl[w][idx] = d;
        else    expRdata[w] = mdl[w][idx];
        if ((a[1:0] != 2'b00) || ((a >> 10) != 32'h0)) expErr[w] = 1'b1;
        if (doPin) pin(w, 0, pn, pv);
        tick();
        setIn(w, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic clearExp();
        for (int i = 0; i < 2; i++) begin
            expStall[i] = 1'b0;
            expRdata[i] = 32'h0;
            expErr[i]   = 1'b0;
        end
    endtask

    initial begin
        rst_i = 1'b0;
        setIn(0, 1'b0, 1'b0, 32'h0, 32'h0);
        setIn(1, 1'b0, 1'b0, 32'h0, 32'h0);
        clearExp();
        tick();
        tick();
        chkEn = 1'b1;
        pin(0, 0, "reset_rdata", 32'h0);
        tick();
        rst_i = 1'b1;
        tick();

        // Store then load the same word
        access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, "");
        tick();
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, "t1_load");

        // Back-to-back loads from 0x10 and 0x14
        access(0, 1'b0, 1'b1, 32'h14, 32'h0BADF00D, 1'b0, 32'h0, "");
        access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, "t2_load10");
        access(0, 1'b1, 1'b0, 32'h14, 32'h0, 1'b1, 32'h0BADF00D, "t2_load14");

        // Index wrap and read+write treated as store
        access(0, 1'b0, 1'b1, 32'h0, 32'h5A5A0001, 1'b0, 32'h0, "");
        access(0, 1'b1, 1'b0, 32'h400, 32'h0, 1'b1, 32'h5A5A0001, "t5_wrap");
        access(0, 1'b1, 1'b1, 32'h8, 32'h12345678, 1'b1, 32'h5A5A0001, "t5_both_holds");
        access(0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 32'h12345678, "t5_both_wrote");

        // Reset during BUSY of a store: the store is discarded
        access(0, 1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, 1'b0, 32'h0, "");
        setIn(0, 1'b0, 1'b1, 32'h20, 32'h11111111);
        expStall[0] = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        clearExp();
        pin(0, 0, "t4_rdata_reset", 32'h0);
        tick();
        setIn(0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_i = 1'b1;
        tick();
        access(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 32'hA5A5A5A5, "t4_old_kept");

        // LATENCY=1 instance
        access(1, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 1'b0, 32'h0, "");
        access(1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 32'hCAFEF00D, "t3_lat1_load");
        tick();

        // Misaligned load, then a clean access, then reset
        access(0, 1'b1, 1'b0, 32'h13, 32'h0, 1'b1, 32'hDEADBEEF, "t6_misaligned_load");
`ifdef DMEM_ERR_EN
        pin(0, 1, "t6_err_set", 32'h1);
`endif
        access(0, 1'b1, 1'b0, 32'h14, 32'h0, 1'b1, 32'h0BADF00D, "t6_clean");
`ifdef DMEM_ERR_EN
        pin(0, 1, "t6_err_sticky", 32'h1);
`endif
        tick();
        rst_i = 1'b0;
        clearExp();
`ifdef DMEM_ERR_EN
        pin(0, 1, "t6_err_reset", 32'h0);
`else
        pin(0, 0, "final_reset_rdata", 32'h0);
`endif
        tick();
        rst_i = 1'b1;
        tick();
        tick();
        chkEn = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
